avr_uart_rx: RTL and testbench
==============================

AVR_UART_RX -- requirements
Module: avr_uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, the clk frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 500000, the serial bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (100 at defaults), integer division.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port rx, input, 1 bit: serial line from AVR Tx (avr_tx); idle high, asynchronous to clk.
REQ-006 SHALL have port data, output, 8 bits: received byte.
REQ-007 SHALL have port valid, output, 1 bit: data holds an unconsumed byte.
REQ-008 SHALL have port ready, input, 1 bit: consumer accepts data.
REQ-009 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-010 SHALL have port frame_err, output, 1 bit: one-cycle pulse on bad stop bit.
REQ-011 SHALL have port overrun, output, 1 bit: one-cycle pulse when a byte is dropped.
REQ-012 SHALL have port parity_err, output, 1 bit: one-cycle pulse on parity mismatch.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value rs.
REQ-014 SHALL implement states IDLE, START, DATA, STOP (plus PARITY per REQ-026); one bit-timer counter 0..CLKS_PER_BIT-1 and one 3-bit bit index.
REQ-015 IDLE -> START on rs falling edge (previous rs 1, current 0); timer cleared.
REQ-016 START: after CLKS_PER_BIT/2 cycles sample rs; 0 -> DATA, 1 -> IDLE (glitch, no outputs change).
REQ-017 DATA: sample every CLKS_PER_BIT cycles, shift LSB first; after the 8th sample -> STOP.
REQ-018 STOP: sample after CLKS_PER_BIT cycles; 1 -> byte accepted per REQ-020; 0 -> frame_err pulse, byte discarded. Either case -> IDLE.
REQ-019 Sample points relative to the detected falling edge at cycle t: start t+CPB/2, bit k (k=0..7) t+CPB/2+(k+1)*CPB, stop t+CPB/2+9*CPB; valid rises the cycle after the stop sample.
REQ-020 Handshake: transfer when valid && ready; valid and data held stable until transfer; valid deasserts the cycle after transfer unless a new byte loads that same cycle.
REQ-021 Byte accepted while valid=1 and ready=0: new byte dropped, data unchanged, overrun pulses.
REQ-022 Byte accepted in the same cycle as a transfer: new byte loads, valid stays 1, no overrun.
REQ-023 Error pulses SHALL be exactly one cycle and never coincide with a load of data.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, counters 0, synchronizer flops 1, data 0x00, valid/busy/frame_err/overrun/parity_err 0.
REQ-025 Reset mid-frame SHALL abandon the frame; after release the first falling edge starts a new frame.

Configuration
REQ-026 With AVR_RX_PARITY_EN defined: DATA -> PARITY -> STOP; PARITY samples one bit, even parity over the 8 data bits; mismatch -> parity_err pulse, byte discarded, stop bit still checked.
REQ-027 Without AVR_RX_PARITY_EN: no PARITY state, DATA -> STOP, parity_err tied 0; the port list is identical in both builds.

Structure
REQ-028 Shared package avr_uart_pkg SHALL hold the state enum typedef, DATA_BITS = 8 and the idle line level.
REQ-029 The 2-flop synchronizer SHALL be a sub-module sync_2ff (reset value parameter, here 1); everything else lives in avr_uart_rx.

Verification (CLK_FREQ=50000000, BAUD=500000, CPB=100)
REQ-030 Frame 0xA5, ready=1 -> data=0xA5, valid high exactly 1 cycle, rising 951 cycles after the synchronized falling edge.
REQ-031 rx low for 30 cycles, then high -> no valid and no error pulse; busy returns low; a following 0x3C frame is received correctly.
REQ-032 Frame 0x3C with stop bit 0 -> frame_err single pulse, valid stays 0, data unchanged.
REQ-033 Frames 0x11 then 0x22, ready=0 -> data=0x11, valid held, overrun pulses once at the 0x22 stop sample; ready=1 -> valid drops next cycle.
REQ-034 rst_n low during bit 3 of 0xFF, released, then frame 0x5A -> all outputs 0 during reset, then data=0x5A, valid=1.
REQ-035 (AVR_RX_PARITY_EN) Frame 0x07 with parity bit 0 -> parity_err pulse, no valid; with parity bit 1 -> data=0x07, valid=1.

Source files
------------

// File: rtl/avr_uart_pkg.sv
// Shared definitions for the AVR UART receiver: FSM state type, frame width, idle line level.
// The PARITY state exists only when AVR_RX_PARITY_EN is defined.
package avr_uart_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam logic        IDLE_LEVEL = 1'b1;

`ifdef AVR_RX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_t;
`endif

endpackage

// File: rtl/avr_uart_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; both flops reset to RESET_VAL.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/avr_uart_rx.sv
// 8N1 UART receiver for the AVR Tx line with a valid/ready byte output and error pulses.
// Define AVR_RX_PARITY_EN to add an even-parity bit between the data and the stop bit.
module avr_uart_rx
  import avr_uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned BAUD     = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned TW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL = TW'(CLKS_PER_BIT - 1);

  rx_state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          rs, rs_prev;
`ifdef AVR_RX_PARITY_EN
  logic          perr_q, perr_d;
  logic          pbad_q, pbad_d;
`endif

  sync_2ff #(.RESET_VAL(IDLE_LEVEL)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rs)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      rs_prev <= IDLE_LEVEL;
`ifdef AVR_RX_PARITY_EN
      perr_q  <= 1'b0;
      pbad_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      rs_prev <= rs;
`ifdef AVR_RX_PARITY_EN
      perr_q  <= perr_d;
      pbad_q  <= pbad_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
`ifdef AVR_RX_PARITY_EN
    perr_d  = 1'b0;
    pbad_d  = pbad_q;
`endif

    // A transfer drops valid; a byte loaded at the stop sample below overrides it.
    if (valid_q && ready) valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        bit_d   = '0;
`ifdef AVR_RX_PARITY_EN
        pbad_d  = 1'b0;
`endif
        if (rs_prev == IDLE_LEVEL && rs != IDLE_LEVEL) state_d = ST_START;
      end
      ST_START: begin
        if (timer_q == HALF) begin
          timer_d = '0;
          state_d = (rs == IDLE_LEVEL) ? ST_IDLE : ST_DATA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (timer_q == FULL) begin
          timer_d = '0;
          shreg_d = {rs, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'(DATA_BITS - 1)) begin
`ifdef AVR_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
`ifdef AVR_RX_PARITY_EN
      ST_PARITY: begin
        if (timer_q == FULL) begin
          timer_d = '0;
          pbad_d  = (rs != ^shreg_q);
          perr_d  = (rs != ^shreg_q);
          state_d = ST_STOP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (timer_q == FULL) begin
          timer_d = '0;
          state_d = ST_IDLE;
          if (rs != IDLE_LEVEL) begin
            ferr_d = 1'b1;
`ifdef AVR_RX_PARITY_EN
          end else if (!pbad_q) begin
`else
          end else begin
`endif
            if (!valid_q || ready) begin
              data_d  = shreg_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign busy      = (state_q != ST_IDLE);
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
`ifdef AVR_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_avr_uart_rx.sv
// Directed self-checking bench for avr_uart_rx at 50 MHz / 500 kbaud (100 clocks per bit).
module tb_avr_uart_rx;

  localparam int unsigned CPB = 100;
`ifdef AVR_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  // rx drive to valid visible: 2 synchronizer edges + 951 cycles (+1 bit with parity)
  localparam int unsigned LATENCY = 953 + (PAR_EN ? CPB : 0);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] data;
  logic       valid, busy, frame_err, overrun, parity_err;

  int n_checks = 0;
  int n_errors = 0;

  int unsigned cyc = 0;
  int unsigned vrise_n = 0, vcyc_n = 0, ferr_n = 0, ovr_n = 0, perr_n = 0;
  int unsigned last_vrise_cyc = 0, last_ovr_cyc = 0;
  logic [7:0]  rise_data = '0;
  logic        valid_prev = 1'b0;

  avr_uart_rx #(.CLK_FREQ(50000000), .BAUD(500000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (valid && !valid_prev) begin
      vrise_n++;
      last_vrise_cyc = cyc;
      rise_data = data;
    end
    if (valid) vcyc_n++;
    if (frame_err) ferr_n++;
    if (overrun) begin
      ovr_n++;
      last_ovr_cyc = cyc;
    end
    if (parity_err) perr_n++;
    valid_prev = valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called on a negedge; returns on a negedge a few idle cycles after the stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par,
                            output int unsigned start_cyc);
    rx = 1'b0;
    start_cyc = cyc;
    repeat (CPB) @(negedge clk);
    for (int unsigned i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    if (PAR_EN) begin
      rx = par;
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  int unsigned t0, t1, vr0, vc0, fe0, ov0, pe0;

  task automatic snap();
    vr0 = vrise_n; vc0 = vcyc_n; fe0 = ferr_n; ov0 = ovr_n; pe0 = perr_n;
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("rst_data", 32'(data), 32'h00);
    check("rst_valid", 32'(valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_parity_err", 32'(parity_err), 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // 0xA5 with ready high
    snap();
    send_frame(8'hA5, 1'b1, ^8'hA5, t0);
    repeat (10) @(negedge clk);
    check("a5_data", 32'(rise_data), 32'hA5);
    check("a5_rises", vrise_n - vr0, 1);
    check("a5_valid_cycles", vcyc_n - vc0, 1);
    check("a5_latency", last_vrise_cyc - t0, LATENCY);
    check("a5_frame_err", ferr_n - fe0, 0);
    check("a5_busy_after", 32'(busy), 0);

    // start-bit glitch
    snap();
    rx = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_busy_during", 32'(busy), 1);
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    check("glitch_rises", vrise_n - vr0, 0);
    check("glitch_frame_err", ferr_n - fe0, 0);
    check("glitch_overrun", ovr_n - ov0, 0);
    check("glitch_busy_after", 32'(busy), 0);
    snap();
    send_frame(8'h3C, 1'b1, ^8'h3C, t0);
    repeat (5) @(negedge clk);
    check("post_glitch_data", 32'(rise_data), 32'h3C);
    check("post_glitch_rises", vrise_n - vr0, 1);

    // bad stop bit
    snap();
    send_frame(8'h3C, 1'b0, ^8'h3C, t0);
    repeat (10) @(negedge clk);
    check("ferr_pulses", ferr_n - fe0, 1);
    check("ferr_rises", vrise_n - vr0, 0);
    check("ferr_valid", 32'(valid), 0);
    check("ferr_data", 32'(data), 32'h3C);

    // overrun with ready low
    ready = 1'b0;
    snap();
    send_frame(8'h11, 1'b1, ^8'h11, t0);
    send_frame(8'h22, 1'b1, ^8'h22, t1);
    repeat (10) @(negedge clk);
    check("ovr_data", 32'(data), 32'h11);
    check("ovr_valid", 32'(valid), 1);
    check("ovr_rises", vrise_n - vr0, 1);
    check("ovr_pulses", ovr_n - ov0, 1);
    check("ovr_when", last_ovr_cyc - t1, LATENCY);
    ready = 1'b1;
    @(negedge clk);
    check("ovr_valid_drop", 32'(valid), 0);
    check("ovr_data_after", 32'(data), 32'h11);

    // reset during bit 3 of 0xFF
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB + 50) @(negedge clk);
    check("mid_busy", 32'(busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mr_data", 32'(data), 32'h00);
    check("mr_valid", 32'(valid), 0);
    check("mr_busy", 32'(busy), 0);
    check("mr_frame_err", 32'(frame_err), 0);
    check("mr_overrun", 32'(overrun), 0);
    check("mr_parity_err", 32'(parity_err), 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    snap();
    send_frame(8'h5A, 1'b1, ^8'h5A, t0);
    repeat (5) @(negedge clk);
    check("after_rst_data", 32'(rise_data), 32'h5A);
    check("after_rst_rises", vrise_n - vr0, 1);
    check("after_rst_latency", last_vrise_cyc - t0, LATENCY);
    check("after_rst_frame_err", ferr_n - fe0, 0);

    if (PAR_EN) begin
      snap();
      send_frame(8'h07, 1'b1, 1'b0, t0);
      repeat (10) @(negedge clk);
      check("par_bad_pulses", perr_n - pe0, 1);
      check("par_bad_rises", vrise_n - vr0, 0);
      check("par_bad_frame_err", ferr_n - fe0, 0);
      snap();
      send_frame(8'h07, 1'b1, 1'b1, t0);
      repeat (10) @(negedge clk);
      check("par_ok_data", 32'(rise_data), 32'h07);
      check("par_ok_rises", vrise_n - vr0, 1);
      check("par_ok_pulses", perr_n - pe0, 0);
    end else begin
      check("par_tied_low", perr_n, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
